// File: rtl/anc_pkg.sv
// Shared definitions for the ANC datapath: default widths, FIR controller
// states and the saturation helper also used by the LMS stage.
package anc_pkg;

  localparam int ANC_DATA_W = 16;
  localparam int ANC_COEF_W = 16;
  localparam int ANC_TAPS   = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUTPUT
  } fir_state_e;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: one write port at wr_ptr, one read port addressed
// as an offset backwards from the most recently written slot.
module fir_sample_ring #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     advance,
  input  logic [$clog2(DEPTH)-1:0] rd_offset,
  output logic [DATA_W-1:0]        rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [PTR_W-1:0]  rd_idx;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
    end
    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    wr_ptr_d = advance ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_idx   = wr_ptr_q - rd_offset;
    rd_data  = mem_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// Serial FIR stage: one shared multiplier, one tap per clock, rounded and
// saturated output. Both ports are valid/ready: a transfer happens on a rising
// edge where valid and ready are both high; valid holds with stable data until then.
module fir_serial_mac
  import anc_pkg::*;
#(
  parameter int DATA_W    = ANC_DATA_W,
  parameter int COEF_W    = ANC_COEF_W,
  parameter int TAPS      = ANC_TAPS,
  parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
  parameter int OUT_SHIFT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_sample,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_sample,
  output logic                    busy
);

  localparam int K_W    = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_BIAS = ACC_W'(1) << (OUT_SHIFT - 1);

  fir_state_e state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        out_sample_q, out_sample_d;
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];

  logic                     hist_we;
  logic                     hist_adv;
  logic signed [DATA_W-1:0] hist_rd;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [63:0]       sat;

  fir_sample_ring #(
    .DATA_W (DATA_W),
    .DEPTH  (TAPS)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (hist_we),
    .wr_data   (in_sample),
    .advance   (hist_adv),
    .rd_offset (k_q),
    .rd_data   (hist_rd)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    acc_d        = acc_q;
    out_sample_d = out_sample_q;
    coef_d       = coef_q;
    hist_we      = 1'b0;
    hist_adv     = 1'b0;
    prod         = hist_rd * coef_q[k_q];
    rnd          = (acc_q + RND_BIAS) >>> OUT_SHIFT;
    sat          = sat_to_width({{(64 - ACC_W){rnd[ACC_W-1]}}, rnd}, DATA_W);

    case (state_q)
      IDLE: begin
        // A coefficient written on the accept cycle is visible from MAC cycle 0.
        if (coef_we) begin
          coef_d[coef_addr] = coef_wdata;
        end
        if (in_valid) begin
          hist_we = 1'b1;
          k_d     = '0;
          acc_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        k_d   = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          hist_adv = 1'b1;
          state_d  = ROUND;
        end
      end
      ROUND: begin
        out_sample_d = DATA_W'(sat);
        state_d      = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      acc_q        <= '0;
      out_sample_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      out_sample_q <= out_sample_d;
      coef_q       <= coef_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == OUTPUT);
  assign busy       = (state_q != IDLE);
  assign out_sample = out_sample_q;

endmodule
